// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and the
// latched frame configuration. Also used by the PisoReg transmitter.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    // Frame format captured at start-bit detection
    typedef struct packed {
        logic [1:0] parity_type;
        logic       stop_bits;
        logic       data_length;
    } rx_cfg_t;

    // Parity type 11 behaves exactly like none
    function automatic logic parity_en(input logic [1:0] p);
        return (p == PAR_ODD) || (p == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sipo_sync.sv
// Line synchroniser and start-edge detector for the UART receiver.
// Ports:
//   clk, rst     - baud clock, async active-high reset
//   data_in      - raw serial line
//   idle         - receiver is in IDLE (arming and detection only happen here)
//   s_in         - synchronised line
//   start_det_c  - combinational: armed and line low while idle
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    input  logic idle,
    output logic s_in,
    output logic start_det_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   armed_q;

    // Flops reset high so the idle line is not mistaken for a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            armed_q <= 1'b0;
        end else begin
            sync_q[0] <= data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            // Arm only after seeing the line high in IDLE; consume on detection
            if (idle) begin
                if (sync_q[SYNC_STAGES-1]) begin
                    armed_q <= 1'b1;
                end else if (armed_q) begin
                    armed_q <= 1'b0;
                end
            end
        end
    end

    assign s_in        = sync_q[SYNC_STAGES-1];
    assign start_det_c = idle & armed_q & ~s_in;

endmodule

// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out UART receiver with 16x (OVERSAMPLE) mid-bit sampling.
// Ports:
//   BaudOut      - oversampled baud clock
//   rst          - async active-high reset
//   data_in      - serial line, idles high
//   parity_type  - 00/11 none, 01 odd, 10 even (latched at start)
//   stop_bits    - 0 one, 1 two stop bits (latched at start)
//   data_length  - 0 seven, 1 eight data bits (latched at start)
//   data_out     - received byte, bit 7 = 0 in 7-bit mode
//   rx_active    - frame in progress
//   rx_done      - one-cycle pulse at frame end
//   parity_error - parity mismatch in last frame
//   stop_error   - stop bit sampled low in last frame
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       BaudOut,
    input  logic       rst,
    input  logic       data_in,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       rx_active,
    output logic       rx_done,
    output logic       parity_error,
    output logic       stop_error
);

    localparam int unsigned   CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bits_q, bits_d;
    logic [7:0]    shift_q, shift_d;
    rx_cfg_t       cfg_q, cfg_d;
    logic          perr_q, perr_d;
    logic          serr_q, serr_d;
    logic [7:0]    data_out_d;
    logic          parity_error_d, stop_error_d, rx_active_d, rx_done_d;
    logic          s_in, start_det_c, sample, par_x;
    logic [3:0]    last_data;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (BaudOut),
        .rst        (rst),
        .data_in    (data_in),
        .idle       (state_q == IDLE),
        .s_in       (s_in),
        .start_det_c(start_det_c)
    );

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + CW'(1);
        bits_d         = bits_q;
        shift_d        = shift_q;
        cfg_d          = cfg_q;
        perr_d         = perr_q;
        serr_d         = serr_q;
        data_out_d     = data_out;
        parity_error_d = parity_error;
        stop_error_d   = stop_error;
        par_x          = 1'b0;
        sample         = (cnt_q == CNT_LAST);
        last_data      = cfg_q.data_length ? 4'd8 : 4'd7;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_det_c) begin
                    state_d           = START;
                    cfg_d.parity_type = parity_type;
                    cfg_d.stop_bits   = stop_bits;
                    cfg_d.data_length = data_length;
                    shift_d           = '0;
                    bits_d            = '0;
                    perr_d            = 1'b0;
                    serr_d            = 1'b0;
                end
            end
            START: begin
                // Half-bit check rejects glitches and re-centres the counter
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = s_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d   = '0;
                    shift_d = {s_in, shift_q[7:1]};
                    bits_d  = bits_q + 4'd1;
                    if (bits_q + 4'd1 == last_data) begin
                        bits_d  = '0;
                        state_d = parity_en(cfg_q.parity_type) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    cnt_d   = '0;
                    par_x   = (^shift_q) ^ s_in;
                    perr_d  = (cfg_q.parity_type == PAR_ODD) ? ~par_x : par_x;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    cnt_d = '0;
                    if (!s_in) begin
                        serr_d = 1'b1;
                    end
                    if (!cfg_q.stop_bits || bits_q == 4'd1) begin
                        // Leave at mid-stop-bit so a following start edge is caught
                        state_d        = DONE;
                        bits_d         = '0;
                        data_out_d     = cfg_q.data_length ? shift_q : {1'b0, shift_q[7:1]};
                        parity_error_d = perr_q;
                        stop_error_d   = serr_q | ~s_in;
                    end else begin
                        bits_d = bits_q + 4'd1;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        rx_active_d = (state_d == START) || (state_d == DATA) ||
                      (state_d == PARITY) || (state_d == STOP);
        rx_done_d   = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge BaudOut or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bits_q       <= '0;
            shift_q      <= '0;
            cfg_q        <= '0;
            perr_q       <= 1'b0;
            serr_q       <= 1'b0;
            data_out     <= '0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            rx_active    <= 1'b0;
            rx_done      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bits_q       <= bits_d;
            shift_q      <= shift_d;
            cfg_q        <= cfg_d;
            perr_q       <= perr_d;
            serr_q       <= serr_d;
            data_out     <= data_out_d;
            parity_error <= parity_error_d;
            stop_error   <= stop_error_d;
            rx_active    <= rx_active_d;
            rx_done      <= rx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: directed frames plus random frames,
// compared every cycle against a per-cycle expectation timeline.
module tb_uart_rx_sipo;

    localparam int OS  = 16;
    localparam int ARR = 20000;

    logic       BaudOut = 1'b0;
    logic       rst = 1'b1;
    logic       data_in = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits = 1'b0;
    logic       data_length = 1'b1;
    logic [7:0] data_out;
    logic       rx_active, rx_done, parity_error, stop_error;

    uart_rx_sipo #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .BaudOut     (BaudOut),
        .rst         (rst),
        .data_in     (data_in),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .data_length (data_length),
        .data_out    (data_out),
        .rx_active   (rx_active),
        .rx_done     (rx_done),
        .parity_error(parity_error),
        .stop_error  (stop_error)
    );

    always #5 BaudOut = ~BaudOut;

    int cyc = 0;
    always @(posedge BaudOut) cyc <= cyc + 1;

    // Expected outputs indexed by posedge number
    bit       exp_active[ARR];
    bit       exp_done[ARR];
    bit [7:0] exp_d_at[ARR];
    bit       exp_p_at[ARR];
    bit       exp_s_at[ARR];

    bit [7:0] m_data = 8'h00;
    bit       m_perr = 1'b0;
    bit       m_serr = 1'b0;
    bit       chk_en = 1'b0;
    int       checks = 0;
    int       errors = 0;
    int       dut_dones = 0;
    int       model_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge BaudOut);
        #1;
    endtask

    task automatic idle(input int n);
        data_in = 1'b1;
        repeat (n) tick();
    endtask

    // Frame whose start bit is driven just after posedge p0 and whose last
    // sampled bit has index jl: active from edge p0+3, done at p0+11+16*jl.
    task automatic record_frame(input int p0, input int jl, input bit [7:0] d,
                                input bit pe, input bit se);
        for (int c = p0 + 3; c <= p0 + 10 + OS * jl; c++)
            if (c < ARR) exp_active[c] = 1'b1;
        if (p0 + 11 + OS * jl < ARR) begin
            exp_done[p0 + 11 + OS * jl] = 1'b1;
            exp_d_at[p0 + 11 + OS * jl] = d;
            exp_p_at[p0 + 11 + OS * jl] = pe;
            exp_s_at[p0 + 11 + OS * jl] = se;
        end
        model_frames++;
    endtask

    task automatic send_frame(input bit [7:0] d, input bit len8, input bit [1:0] par,
                              input bit stop2, input bit bad_par, input bit [1:0] bad_stop,
                              input int abort_bits);
        bit q[$];
        bit dp, p, pen, se;
        int n, p0;
        n   = len8 ? 8 : 7;
        pen = (par == 2'b01) || (par == 2'b10);
        dp  = 1'b0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            dp ^= d[i];
        end
        if (pen) begin
            p = ((par == 2'b01) ? ~dp : dp) ^ bad_par;
            q.push_back(p);
        end
        q.push_back(~bad_stop[0]);
        if (stop2) q.push_back(~bad_stop[1]);
        se = bad_stop[0] | (stop2 & bad_stop[1]);
        parity_type = par;
        stop_bits   = stop2;
        data_length = len8;
        p0 = cyc;
        if (abort_bits < 0)
            record_frame(p0, q.size() - 1, len8 ? d : {1'b0, d[6:0]}, pen & bad_par, se);
        else
            for (int c = p0 + 3; c < ARR && c <= p0 + OS * abort_bits; c++) exp_active[c] = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            if (abort_bits >= 0 && i == abort_bits) return;
            data_in = q[i];
            if (i == 1) begin
                // Config changes mid-frame must not affect this frame
                parity_type = 2'($urandom_range(3));
                stop_bits   = 1'($urandom_range(1));
                data_length = 1'($urandom_range(1));
            end
            repeat (OS) tick();
        end
    endtask

    // Per-cycle compare against the expectation timeline
    always @(negedge BaudOut) begin
        if (chk_en && cyc < ARR) begin
            if (exp_done[cyc]) begin
                m_data = exp_d_at[cyc];
                m_perr = exp_p_at[cyc];
                m_serr = exp_s_at[cyc];
            end
            if (rx_done === 1'b1) dut_dones++;
            check("rx_active", 32'(rx_active), 32'(exp_active[cyc]));
            check("rx_done", 32'(rx_done), 32'(exp_done[cyc]));
            check("data_out", 32'(data_out), 32'(m_data));
            check("parity_error", 32'(parity_error), 32'(m_perr));
            check("stop_error", 32'(stop_error), 32'(m_serr));
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bit [7:0] d;
        bit len8, stop2, bpar, lastbad;
        bit [1:0] par, bstop;

        repeat (3) tick();
        check("reset_rx_active", 32'(rx_active), 32'd0);
        check("reset_rx_done", 32'(rx_done), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_parity_error", 32'(parity_error), 32'd0);
        check("reset_stop_error", 32'(stop_error), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(20);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, -1);
        idle(10);
        check("a5_data", 32'(data_out), 32'h0A5);
        check("a5_stop_error", 32'(stop_error), 32'd0);

        // 8O1 0x96 good then bad parity
        send_frame(8'h96, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, -1);
        idle(10);
        check("odd_good_perr", 32'(parity_error), 32'd0);
        send_frame(8'h96, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00, -1);
        idle(10);
        check("odd_bad_perr", 32'(parity_error), 32'd1);
        check("odd_bad_data", 32'(data_out), 32'h096);

        // 7E2 0x4B good then second stop bit low
        send_frame(8'h4B, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, -1);
        idle(10);
        check("7e2_data", 32'(data_out), 32'h04B);
        check("7e2_perr", 32'(parity_error), 32'd0);
        send_frame(8'h4B, 1'b0, 2'b10, 1'b1, 1'b0, 2'b10, -1);
        idle(20);
        check("7e2_stop_error", 32'(stop_error), 32'd1);

        // Short glitch: active pulse only
        for (int c = cyc + 3; c <= cyc + 10; c++) exp_active[c] = 1'b1;
        data_in = 1'b0;
        repeat (5) tick();
        idle(24);
        check("glitch_data_held", 32'(data_out), 32'h04B);

        // Back-to-back 0x00, 0xFF, then reset mid third frame
        send_frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, -1);
        check("b2b_first", 32'(data_out), 32'h000);
        send_frame(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, -1);
        check("b2b_second", 32'(data_out), 32'h0FF);
        send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 5);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_rx_active", 32'(rx_active), 32'd0);
        check("midrst_rx_done", 32'(rx_done), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_parity_error", 32'(parity_error), 32'd0);
        check("midrst_stop_error", 32'(stop_error), 32'd0);
        for (int c = cyc; c < ARR && c < cyc + 400; c++) begin
            exp_active[c] = 1'b0;
            exp_done[c] = 1'b0;
        end
        data_in = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        m_data = 8'h00;
        m_perr = 1'b0;
        m_serr = 1'b0;
        chk_en = 1'b1;
        idle(20);

        // Break: 40 bit times low gives one framing-error frame
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        data_length = 1'b1;
        record_frame(cyc, 9, 8'h00, 1'b0, 1'b1);
        data_in = 1'b0;
        repeat (40 * OS) tick();
        idle(30);
        check("break_data", 32'(data_out), 32'h000);
        check("break_stop_error", 32'(stop_error), 32'd1);
        send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, -1);
        idle(10);
        check("after_break_data", 32'(data_out), 32'h05A);

        // Random frames
        for (int k = 0; k < 30; k++) begin
            d     = 8'($urandom);
            len8  = 1'($urandom_range(1));
            par   = 2'($urandom_range(3));
            stop2 = 1'($urandom_range(1));
            bpar  = ($urandom_range(3) == 0);
            bstop = ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : 2'b00;
            send_frame(d, len8, par, stop2, bpar, bstop, -1);
            lastbad = stop2 ? bstop[1] : bstop[0];
            idle(lastbad ? 20 : int'($urandom_range(12)));
        end
        idle(30);
        check("done_count", 32'(dut_dones), 32'(model_frames));
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
- Serial-in/parallel-out UART receiver. It is the receive-side counterpart of the PisoReg transmit shift register.
- Accepts the serial line, detects the start bit, and samples each bit at mid-bit using a 16x oversampled baud clock.
- Deframes the configured format (7/8 data bits, none/odd/even parity, 1/2 stop bits) and presents the data byte with error flags and a one-cycle done pulse.
- Sits between the line input and the receive data consumer, driven by the same baud generator as the transmitter.

Parameters:
- OVERSAMPLE, 16, BaudOut cycles per bit; must be even and at least 8.
- SYNC_STAGES, 2, number of input synchroniser flops on data_in.

Ports:
- BaudOut  in  1  clock from the baud generator, running at OVERSAMPLE x the bit rate.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  1  serial line; idles high.
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- data_length  in  1  0 = 7 data bits, 1 = 8 data bits.
- data_out  out  8  received data, LSB first on the line; bit 7 = 0 in 7-bit mode.
- rx_active  out  1  high from start-bit detection until the frame ends.
- rx_done  out  1  one-cycle pulse when a frame completes, including frames with errors.
- parity_error  out  1  parity mismatch in the last frame.
- stop_error  out  1  a stop bit sampled low in the last frame (framing error).

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Synchroniser flops reset to 1; the "line seen high" arm flag clears.
  - Reset asserted mid-frame abandons the frame: no rx_done, no flag update.
- Input conditioning: data_in passes through SYNC_STAGES flops. All logic uses only the synchronised value s_in.
- Configuration: parity_type, stop_bits and data_length are latched on entry to START. Changes mid-frame have no effect until the next frame.
- Tick counter: 0..OVERSAMPLE-1, cleared on every state entry. A bit is sampled when the counter reaches OVERSAMPLE-1, except in START.
- IDLE:
  - rx_active = 0.
  - The arm flag sets when s_in = 1.
  - s_in = 0 while armed -> START; rx_active goes to 1 in the same cycle.
  - A line held low after a break or stop error does not retrigger until it has returned high.
- START:
  - At count OVERSAMPLE/2-1, sample s_in (mid start bit).
  - Sample = 1 -> glitch: go to IDLE, no flags, no rx_done.
  - Sample = 0 -> DATA with the counter cleared, so later samples fall at mid-bit.
- DATA:
  - Each sample shifts right into an 8-bit shift register: new bit enters bit 7.
  - After 7 or 8 samples (latched data_length) -> PARITY if latched parity_type is 01 or 10, else STOP.
  - 7-bit result is shift_reg[7:1] right-aligned, with bit 7 = 0.
- PARITY: sample one bit.
  - Odd: error if XOR(data bits, parity bit) = 0.
  - Even: error if XOR = 1.
  - Then -> STOP.
- STOP:
  - Sample one or two stop bits (latched stop_bits).
  - Any sample of 0 sets the internal stop-error bit.
  - After the final stop sample -> DONE. Leaving at mid-stop-bit allows back-to-back frames.
- DONE (one cycle):
  - rx_done = 1.
  - data_out, parity_error and stop_error update together in this cycle.
  - rx_active drops to 0 at this edge. Next state is IDLE.
- Hold and latency:
  - data_out and the error flags hold their values until the next DONE.
  - Line to rx_done latency: SYNC_STAGES + 1 cycles after the final stop bit's mid-sample point.
- Parity type 11 is treated exactly as none; parity_error stays 0.

Decomposition:
- Shared package uart_pkg:
  - Parity encodings PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10.
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, DONE.
  - These constants are shared with PisoReg.
- One sub-module, uart_rx_sync: SYNC_STAGES-deep synchroniser with the arm-flag falling-edge detector.
- The FSM, counters and shift register stay in the top module.

Test Plan:
- 8N1, data 0xA5: line 0,1,0,1,0,0,1,0,1,1 at 16 cycles/bit -> rx_done once; data_out=0xA5; both errors 0; rx_active high for exactly the frame duration.
- 8O1, data 0x96 with parity 1 (correct), then parity 0 -> first frame parity_error=0; second frame parity_error=1 with data_out=0x96.
- 7E2, data 0x4B with parity 0, then a frame whose second stop bit is 0 -> data_out=0x4B and no errors; then stop_error=1 with rx_done still pulsed.
- Line low for 5 cycles then high (glitch shorter than half a bit) -> no rx_done; rx_active pulses and returns to 0; outputs unchanged.
- Two back-to-back 8N1 frames 0x00 then 0xFF with no idle gap; rst asserted mid-byte on a third frame -> data_out=0x00 then 0xFF; third frame gives no rx_done; all outputs read 0 immediately on reset.
- Line held low (break) for 40 bit times -> single rx_done with data_out=0x00 and stop_error=1; no further frames until the line goes high and then falls again.
